// File: rtl/csr_file_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, Zicsr op
// encodings, mstatus bit positions, mcause codes and the misa value.
package csr_defs;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  typedef enum logic [2:0] {
    OP_RW  = 3'b001,
    OP_RS  = 3'b010,
    OP_RC  = 3'b011,
    OP_RWI = 3'b101,
    OP_RSI = 3'b110,
    OP_RCI = 3'b111
  } csr_op_e;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  localparam logic [31:0] MCAUSE_ILLEGAL    = 32'd2;
  localparam logic [31:0] MCAUSE_BREAKPOINT = 32'd3;
  localparam logic [31:0] MCAUSE_ECALL_M    = 32'd11;

  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

  // MPP is hardwired to machine mode, so only MIE/MPIE vary.
  function automatic logic [31:0] mstatus_view(input logic mie, input logic mpie);
    logic [31:0] v;
    v = 32'h0000_1800;
    v[MSTATUS_MIE]  = mie;
    v[MSTATUS_MPIE] = mpie;
    return v;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with per-half overwrite; a write to either
// half takes precedence over that cycle's increment.
module csr_counter64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [31:0] lo,
  output logic [31:0] hi
);

  logic [63:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 64'd0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) count[31:0]  <= wdata;
      if (wr_hi) count[63:32] <= wdata;
    end else if (inc) begin
      count <= count + 64'd1;
    end
  end

  assign lo = count[31:0];
  assign hi = count[63:32];

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file and trap state for the RV32I core.
// Optional 64-bit mcycle/minstret counters are enabled by CSR_COUNTERS_EN.
module csr_file
  import csr_defs::*;
#(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] csr_addr,
  input  logic [2:0]  csr_op,
  input  logic        csr_we,
  input  logic        csr_src,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  uimm,
  input  logic [4:0]  rs1_idx,
  output logic [31:0] csr_rdata,
  output logic        illegal_csr,
  input  logic        trap_entry,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_val,
  input  logic        mret,
  input  logic        instret_inc,
  output logic [31:0] trap_vector,
  output logic [31:0] mepc_out,
  output logic        mstatus_mie
);

  logic        st_mie;
  logic        st_mpie;
  logic [31:0] mie_q;
  logic [31:0] mip_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;

  logic [31:0] src;
  logic [31:0] wdata;
  logic        implemented;
  logic        set_clear_op;
  logic        valid_op;
  logic        suppressed;
  logic        wr_req;
  logic        commit;

`ifdef CSR_COUNTERS_EN
  logic [31:0] cyc_lo, cyc_hi, ins_lo, ins_hi;
  logic        cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi;
  logic        unused_ok;
  assign unused_ok = csr_op[2];
`else
  logic [1:0]  unused_ok;
  assign unused_ok = {csr_op[2], instret_inc};
`endif

  // Read mux: the value returned is always the pre-write contents.
  always_comb begin
    csr_rdata   = 32'd0;
    implemented = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:  csr_rdata = mstatus_view(st_mie, st_mpie);
      CSR_MISA:     csr_rdata = MISA_VALUE;
      CSR_MIE:      csr_rdata = mie_q;
      CSR_MTVEC:    csr_rdata = mtvec_q;
      CSR_MSCRATCH: csr_rdata = mscratch_q;
      CSR_MEPC:     csr_rdata = mepc_q;
      CSR_MCAUSE:   csr_rdata = mcause_q;
      CSR_MTVAL:    csr_rdata = mtval_q;
      CSR_MIP:      csr_rdata = mip_q;
      CSR_MHARTID:  csr_rdata = HART_ID;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE, CSR_CYCLE:       csr_rdata = cyc_lo;
      CSR_MCYCLEH, CSR_CYCLEH:     csr_rdata = cyc_hi;
      CSR_MINSTRET, CSR_INSTRET:   csr_rdata = ins_lo;
      CSR_MINSTRETH, CSR_INSTRETH: csr_rdata = ins_hi;
`endif
      default:      implemented = 1'b0;
    endcase
  end

  assign src          = csr_src ? {27'd0, uimm} : rs1_data;
  assign valid_op     = (csr_op[1:0] != 2'b00);
  assign set_clear_op = csr_op[1];
  // Set/clear forms with a zero rs1/uimm field are pure reads.
  assign suppressed   = set_clear_op && (csr_src ? (uimm == 5'd0) : (rs1_idx == 5'd0));
  assign wr_req       = csr_we && valid_op && !suppressed;

  assign illegal_csr = csr_we && (!implemented || (wr_req && (csr_addr[11:10] == 2'b11)));
  assign commit      = wr_req && !illegal_csr && !trap_entry;

  always_comb begin
    case (csr_op[1:0])
      2'b10:   wdata = csr_rdata | src;
      2'b11:   wdata = csr_rdata & ~src;
      default: wdata = src;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      mie_q      <= 32'd0;
      mip_q      <= 32'd0;
      mtvec_q    <= MTVEC_RESET & ~32'h3;
      mscratch_q <= 32'd0;
      mepc_q     <= 32'd0;
      mcause_q   <= 32'd0;
      mtval_q    <= 32'd0;
    end else if (trap_entry) begin
      mepc_q   <= trap_pc & ~32'h3;
      mcause_q <= trap_cause;
      mtval_q  <= trap_val;
      st_mpie  <= st_mie;
      st_mie   <= 1'b0;
    end else begin
      if (mret) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end
      if (commit) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            if (!mret) begin
              st_mie  <= wdata[MSTATUS_MIE];
              st_mpie <= wdata[MSTATUS_MPIE];
            end
          end
          CSR_MIE:      mie_q      <= wdata;
          CSR_MIP:      mip_q      <= wdata;
          CSR_MTVEC:    mtvec_q    <= wdata & ~32'h3;
          CSR_MSCRATCH: mscratch_q <= wdata;
          CSR_MEPC:     mepc_q     <= wdata & ~32'h3;
          CSR_MCAUSE:   mcause_q   <= wdata;
          CSR_MTVAL:    mtval_q    <= wdata;
          default: ;
        endcase
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  assign cyc_wr_lo = commit && (csr_addr == CSR_MCYCLE);
  assign cyc_wr_hi = commit && (csr_addr == CSR_MCYCLEH);
  assign ins_wr_lo = commit && (csr_addr == CSR_MINSTRET);
  assign ins_wr_hi = commit && (csr_addr == CSR_MINSTRETH);

  csr_counter64 u_mcycle (
    .clk   (clk),
    .reset (reset),
    .inc   (1'b1),
    .wr_lo (cyc_wr_lo),
    .wr_hi (cyc_wr_hi),
    .wdata (wdata),
    .lo    (cyc_lo),
    .hi    (cyc_hi)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .reset (reset),
    .inc   (instret_inc),
    .wr_lo (ins_wr_lo),
    .wr_hi (ins_wr_hi),
    .wdata (wdata),
    .lo    (ins_lo),
    .hi    (ins_hi)
  );
`endif

  assign trap_vector = mtvec_q;
  assign mepc_out    = mepc_q;
  assign mstatus_mie = st_mie;

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: hand-computed expectations checked with
// immediate assertions; counter steps follow CSR_COUNTERS_EN.
module tb_csr_file;

  localparam logic [31:0] HART = 32'd5;
  localparam logic [31:0] MTV  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] csr_addr;
  logic [2:0]  csr_op;
  logic        csr_we;
  logic        csr_src;
  logic [31:0] rs1_data;
  logic [4:0]  uimm;
  logic [4:0]  rs1_idx;
  logic [31:0] csr_rdata;
  logic        illegal_csr;
  logic        trap_entry;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_val;
  logic        mret;
  logic        instret_inc;
  logic [31:0] trap_vector;
  logic [31:0] mepc_out;
  logic        mstatus_mie;

  int total = 0;
  int bad   = 0;

  csr_file #(.HART_ID(HART), .MTVEC_RESET(MTV)) dut (
    .clk         (clk),
    .reset       (reset),
    .csr_addr    (csr_addr),
    .csr_op      (csr_op),
    .csr_we      (csr_we),
    .csr_src     (csr_src),
    .rs1_data    (rs1_data),
    .uimm        (uimm),
    .rs1_idx     (rs1_idx),
    .csr_rdata   (csr_rdata),
    .illegal_csr (illegal_csr),
    .trap_entry  (trap_entry),
    .trap_cause  (trap_cause),
    .trap_pc     (trap_pc),
    .trap_val    (trap_val),
    .mret        (mret),
    .instret_inc (instret_inc),
    .trap_vector (trap_vector),
    .mepc_out    (mepc_out),
    .mstatus_mie (mstatus_mie)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    csr_we = 1'b0; csr_op = 3'b000; csr_src = 1'b0; rs1_data = 32'd0;
    uimm = 5'd0; rs1_idx = 5'd0; trap_entry = 1'b0; trap_cause = 32'd0;
    trap_pc = 32'd0; trap_val = 32'd0; mret = 1'b0; instret_inc = 1'b0;
  endtask

  task automatic csr_cmd(input logic [11:0] a, input logic [2:0] op, input logic s,
                         input logic [31:0] r, input logic [4:0] u, input logic [4:0] idx);
    csr_addr = a; csr_op = op; csr_src = s; rs1_data = r; uimm = u; rs1_idx = idx;
    csr_we = 1'b1;
    #1;
  endtask

  task automatic read_at(input logic [11:0] a);
    csr_we = 1'b0; csr_addr = a;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    csr_addr = 12'h000;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    read_at(12'h300); check("rst_mstatus", csr_rdata, 32'h0000_1800);
    read_at(12'h305); check("rst_mtvec", csr_rdata, MTV);
    read_at(12'h301); check("rst_misa", csr_rdata, 32'h4000_0100);
    check("rst_trap_vector", trap_vector, MTV);
    check("rst_mepc_out", mepc_out, 32'd0);
    check("rst_mie", {31'd0, mstatus_mie}, 32'd0);

    csr_cmd(12'h340, 3'b001, 1'b0, 32'hDEAD_BEEF, 5'd0, 5'd1);
    check("rw_scratch_old", csr_rdata, 32'd0);
    tick();
    csr_cmd(12'h340, 3'b010, 1'b0, 32'h0000_FFFF, 5'd0, 5'd0);
    check("rs0_rdata", csr_rdata, 32'hDEAD_BEEF);
    check("rs0_illegal", {31'd0, illegal_csr}, 32'd0);
    tick();
    read_at(12'h340); check("rs0_nowrite", csr_rdata, 32'hDEAD_BEEF);

    csr_cmd(12'h340, 3'b011, 1'b0, 32'hFFFF_0000, 5'd0, 5'd2);
    tick();
    read_at(12'h340); check("rc_scratch", csr_rdata, 32'h0000_BEEF);

    csr_cmd(12'h344, 3'b101, 1'b1, 32'hFFFF_FFFF, 5'd19, 5'd19);
    tick();
    read_at(12'h344); check("rwi_mip", csr_rdata, 32'h0000_0013);

    csr_cmd(12'h300, 3'b110, 1'b1, 32'd0, 5'd8, 5'd8);
    check("rsi_old", csr_rdata, 32'h0000_1800);
    tick();
    check("rsi_mie_out", {31'd0, mstatus_mie}, 32'd1);
    read_at(12'h300); check("rsi_mstatus", csr_rdata, 32'h0000_1808);

    trap_entry = 1'b1; trap_cause = 32'd11; trap_pc = 32'h104; trap_val = 32'd0;
    tick();
    check("trap_mepc_out", mepc_out, 32'h104);
    read_at(12'h342); check("trap_mcause", csr_rdata, 32'd11);
    read_at(12'h300); check("trap_mstatus", csr_rdata, 32'h0000_1880);
    check("trap_mie_out", {31'd0, mstatus_mie}, 32'd0);

    mret = 1'b1;
    tick();
    read_at(12'h300); check("mret_mstatus", csr_rdata, 32'h0000_1888);
    check("mret_mie_out", {31'd0, mstatus_mie}, 32'd1);

    csr_cmd(12'h341, 3'b001, 1'b0, 32'h200, 5'd0, 5'd3);
    trap_entry = 1'b1; trap_cause = 32'd2; trap_pc = 32'h208; trap_val = 32'h55;
    tick();
    check("trapwr_mepc", mepc_out, 32'h208);
    read_at(12'h343); check("trapwr_mtval", csr_rdata, 32'h55);
    read_at(12'h300); check("trapwr_mstatus", csr_rdata, 32'h0000_1880);

    csr_cmd(12'hF14, 3'b001, 1'b0, 32'h1234, 5'd0, 5'd1);
    check("hart_rw_illegal", {31'd0, illegal_csr}, 32'd1);
    tick();
    csr_cmd(12'hF14, 3'b010, 1'b0, 32'h1234, 5'd0, 5'd0);
    check("hart_rs0_illegal", {31'd0, illegal_csr}, 32'd0);
    check("hart_rs0_rdata", csr_rdata, HART);
    tick();

    csr_cmd(12'h305, 3'b001, 1'b0, 32'h0000_0203, 5'd0, 5'd4);
    check("mtvec_before", trap_vector, MTV);
    tick();
    check("mtvec_after", trap_vector, 32'h0000_0200);

    csr_cmd(12'h341, 3'b001, 1'b0, 32'h0000_0123, 5'd0, 5'd4);
    tick();
    check("mepc_align", mepc_out, 32'h0000_0120);

    csr_cmd(12'h7C0, 3'b010, 1'b0, 32'd1, 5'd0, 5'd0);
    check("unimpl_illegal", {31'd0, illegal_csr}, 32'd1);
    check("unimpl_rdata", csr_rdata, 32'd0);
    tick();

    csr_cmd(12'h300, 3'b001, 1'b0, 32'd0, 5'd0, 5'd1);
    mret = 1'b1;
    tick();
    read_at(12'h300); check("mret_wins", csr_rdata, 32'h0000_1888);

`ifdef CSR_COUNTERS_EN
    csr_cmd(12'hB00, 3'b001, 1'b0, 32'hFFFF_FFFF, 5'd0, 5'd1);
    check("mcycle_legal", {31'd0, illegal_csr}, 32'd0);
    tick();
    read_at(12'hB00); check("mcycle_lo_wr", csr_rdata, 32'hFFFF_FFFF);
    read_at(12'hB80); check("mcycle_hi_wr", csr_rdata, 32'd0);
    tick();
    read_at(12'hB00); check("mcycle_lo_wrap", csr_rdata, 32'd0);
    read_at(12'hC80); check("cycleh_carry", csr_rdata, 32'd1);
    csr_cmd(12'hB02, 3'b001, 1'b0, 32'd7, 5'd0, 5'd1);
    instret_inc = 1'b1;
    tick();
    read_at(12'hC02); check("instret_wr_wins", csr_rdata, 32'd7);
    instret_inc = 1'b1;
    tick();
    read_at(12'hB02); check("instret_inc", csr_rdata, 32'd8);
    csr_cmd(12'hC00, 3'b001, 1'b0, 32'd0, 5'd0, 5'd1);
    check("cycle_ro_illegal", {31'd0, illegal_csr}, 32'd1);
    tick();
`else
    csr_cmd(12'hB00, 3'b001, 1'b0, 32'hFFFF_FFFF, 5'd0, 5'd1);
    check("mcycle_absent_illegal", {31'd0, illegal_csr}, 32'd1);
    check("mcycle_absent_rdata", csr_rdata, 32'd0);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
